// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, fills a small prefetch queue from
// instruction memory, and hands words to decode. Optional feature: FETCH_MISALIGN_TRAP_EN.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          QDEPTH   = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] imemAddr,
   input  logic [31:0] imemData,
   output logic [31:0] instrOut,
   output logic [31:0] pcOut,
   output logic        instrValid,
   input  logic        instrReady,
   input  logic        redirect,
   input  logic [31:0] redirectTarget,
   output logic        fetchFault
);

   localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(QDEPTH);

   logic [31:0]   fetch_pc;
   logic [31:0]   q_pc    [QDEPTH];
   logic [31:0]   q_instr [QDEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] count;
   logic [31:0]   target_pc;
   logic          fault;
   logic          pop;
   logic          push;

`ifdef FETCH_MISALIGN_TRAP_EN
   logic misaligned;

   assign target_pc  = redirectTarget;
   assign misaligned = |redirectTarget[1:0];

   // The fault flag only changes on a redirect; it blocks fetch until an aligned one arrives.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fault <= 1'b0;
      end else if (redirect) begin
         fault <= misaligned;
      end
   end
`else
   logic unused_target_bits;

   assign target_pc          = {redirectTarget[31:2], 2'b00};
   assign unused_target_bits = ^redirectTarget[1:0];
   assign fault              = 1'b0;
`endif

   assign imemAddr   = fetch_pc;
   assign fetchFault = fault;
   assign instrValid = (count != '0) && !redirect && !fault;
   assign instrOut   = q_instr[rd_ptr];
   assign pcOut      = q_pc[rd_ptr];

   // A full queue may still accept a word when the head leaves in the same cycle.
   assign pop  = instrValid && instrReady;
   assign push = !redirect && !fault && ((count < DEPTH_C) || pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc <= RESET_PC;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         for (int i = 0; i < QDEPTH; i++) begin
            q_pc[i]    <= '0;
            q_instr[i] <= '0;
         end
      end else if (redirect) begin
         fetch_pc <= target_pc;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
      end else begin
         if (push) begin
            q_pc[wr_ptr]    <= fetch_pc;
            q_instr[wr_ptr] <= imemData;
            wr_ptr          <= wr_ptr + PW'(1);
            fetch_pc        <= fetch_pc + 32'd4;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule
